lspc_timer_ctrl: RTL and testbench

Programmable raster-interval timer controller built around a 32-bit up-counter: eight cascaded 4-bit load/enable/carry stages, modelled in-block. Sequences load, count-enable and carry for the chain. Handles the host reload registers, the three reload triggers (register write, frame start, expiry) and the timer interrupt flag. Sits in the video-timing section next to the pixel/line counters and feeds the interrupt controller.

---
 rtl/lspc_timer_ctrl.sv | 103 ++++++++++
 tb/tb_lspc_timer_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lspc_timer_ctrl.sv
// Raster-interval timer: 4-bit load/enable/carry chain counting up from ~RELOAD,
// host reload/control/ack registers, three reload triggers and a level IRQ.
module lspc_timer_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             TICK,
    input  logic             VBL_START,
    input  logic             WR,
    input  logic [1:0]       ADDR,
    input  logic [15:0]      DIN,
    output logic [WIDTH-1:0] COUNT,
    output logic [WIDTH-1:0] RELOAD,
    output logic             IRQ,
    output logic             EXPIRED,
    output logic             RUNNING
);
    // state | meaning
    // IDLE  | EN=0, COUNT holds (loads still land)
    // RUN   | EN=1, chain advances on TICK
    // HALT  | expired without LD_EXP, COUNT parked at 0 until a load
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    localparam int NSTG   = WIDTH / 4;
    localparam int HI_LSB = (WIDTH >= 32) ? 16 : 0;

    state_t           state, state_next;
    logic             ld_wr, ld_vbl, ld_exp;
    logic [WIDTH-1:0] reload_next, count_next;
    logic [NSTG:0]    carry;
    logic             expiry, load, wr_ctrl, wr_ack;

    assign wr_ctrl = WR && (ADDR == 2'd2);
    assign wr_ack  = WR && (ADDR == 2'd3) && DIN[1];

    always_comb begin
        reload_next = RELOAD;
        if (WR && (ADDR == 2'd1))
            reload_next[15:0] = DIN;
        if ((WIDTH >= 32) && WR && (ADDR == 2'd0))
            reload_next[HI_LSB +: 16] = DIN;

        // carry ripples through the nibble stages; the top carry-out is expiry
        carry    = '0;
        carry[0] = (state == S_RUN) && TICK;
        for (int i = 0; i < NSTG; i++)
            carry[i+1] = carry[i] && (&COUNT[4*i +: 4]);
        expiry = carry[NSTG];

        load = (WR && (ADDR == 2'd1) && ld_wr) ||
               (VBL_START && ld_vbl) ||
               (expiry && ld_exp);

        count_next = COUNT;
        for (int i = 0; i < NSTG; i++) begin
            if (load)
                count_next[4*i +: 4] = ~reload_next[4*i +: 4];
            else if (carry[i])
                count_next[4*i +: 4] = COUNT[4*i +: 4] + 4'd1;
        end

        state_next = state;
        if (expiry && !ld_exp)
            state_next = S_HALT;
        if (load && (state == S_HALT))
            state_next = S_RUN;
        if (wr_ctrl) begin
            if (!DIN[4])
                state_next = S_IDLE;
            else if (state == S_IDLE)
                state_next = S_RUN;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            COUNT   <= '0;
            RELOAD  <= '0;
            state   <= S_IDLE;
            ld_wr   <= 1'b0;
            ld_vbl  <= 1'b0;
            ld_exp  <= 1'b0;
            IRQ     <= 1'b0;
            EXPIRED <= 1'b0;
            RUNNING <= 1'b0;
        end else begin
            COUNT   <= count_next;
            RELOAD  <= reload_next;
            state   <= state_next;
            RUNNING <= (state_next == S_RUN);
            EXPIRED <= expiry;
            if (wr_ctrl)
                {ld_exp, ld_vbl, ld_wr} <= DIN[7:5];
            // a same-cycle ack loses to a fresh expiry
            if (expiry)
                IRQ <= 1'b1;
            else if (wr_ack)
                IRQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lspc_timer_ctrl.sv
// Directed bench for lspc_timer_ctrl: arithmetic reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_lspc_timer_ctrl;
    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        TICK = 1'b0, VBL_START = 1'b0, WR = 1'b0;
    logic [1:0]  ADDR = 2'd0;
    logic [15:0] DIN = 16'd0;
    logic [31:0] COUNT, RELOAD;
    logic        IRQ, EXPIRED, RUNNING;

    int n_checks = 0;
    int n_errors = 0;

    lspc_timer_ctrl #(.WIDTH(32)) dut (
        .CK(CK), .RST(RST), .TICK(TICK), .VBL_START(VBL_START), .WR(WR),
        .ADDR(ADDR), .DIN(DIN), .COUNT(COUNT), .RELOAD(RELOAD),
        .IRQ(IRQ), .EXPIRED(EXPIRED), .RUNNING(RUNNING)
    );

    always #5 CK = ~CK;

    // reference model: plain arithmetic on the count value
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    logic [31:0] m_count = 0, m_reload = 0;
    int          m_state = M_IDLE;
    logic        m_ldwr = 0, m_ldvbl = 0, m_ldexp = 0;
    logic        m_irq = 0, m_exp = 0, m_valid = 0;

    logic [31:0] t_rl, t_count;
    logic        t_exp, t_ld;
    int          t_state;

    always_comb begin
        t_rl = m_reload;
        if (WR && ADDR == 2'd0) t_rl[31:16] = DIN;
        if (WR && ADDR == 2'd1) t_rl[15:0]  = DIN;
        t_exp = (m_state == M_RUN) && TICK && (m_count == 32'hFFFF_FFFF);
        t_ld  = (WR && ADDR == 2'd1 && m_ldwr) || (VBL_START && m_ldvbl) || (t_exp && m_ldexp);
        if (t_ld)                          t_count = ~t_rl;
        else if (m_state == M_RUN && TICK) t_count = m_count + 32'd1;
        else                               t_count = m_count;
        t_state = m_state;
        if (t_exp && !m_ldexp)          t_state = M_HALT;
        if (t_ld && m_state == M_HALT)  t_state = M_RUN;
        if (WR && ADDR == 2'd2) begin
            if (!DIN[4])                t_state = M_IDLE;
            else if (m_state == M_IDLE) t_state = M_RUN;
        end
    end

    always @(posedge CK) begin
        m_valid <= 1'b1;
        if (RST) begin
            m_count <= 0; m_reload <= 0; m_state <= M_IDLE;
            m_ldwr <= 0; m_ldvbl <= 0; m_ldexp <= 0; m_irq <= 0; m_exp <= 0;
        end else begin
            m_count  <= t_count;
            m_reload <= t_rl;
            m_state  <= t_state;
            m_exp    <= t_exp;
            if (WR && ADDR == 2'd2) begin
                m_ldwr <= DIN[5]; m_ldvbl <= DIN[6]; m_ldexp <= DIN[7];
            end
            if (t_exp)                          m_irq <= 1'b1;
            else if (WR && ADDR == 2'd3 && DIN[1]) m_irq <= 1'b0;
        end
    end

    always @(negedge CK) begin
        if (m_valid) begin
            n_checks++;
            if ({COUNT, RELOAD, IRQ, EXPIRED, RUNNING} !==
                {m_count, m_reload, m_irq, m_exp, (m_state == M_RUN)}) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t: COUNT %h/%h RELOAD %h/%h IRQ %b/%b EXPIRED %b/%b RUNNING %b/%b (got/expected)",
                         $time, COUNT, m_count, RELOAD, m_reload, IRQ, m_irq,
                         EXPIRED, m_exp, RUNNING, (m_state == M_RUN));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic tick, input logic vbl, input logic wr,
                        input logic [1:0] addr, input logic [15:0] din);
        TICK = tick; VBL_START = vbl; WR = wr; ADDR = addr; DIN = din;
        @(negedge CK);
        TICK = 0; VBL_START = 0; WR = 0; ADDR = 2'd0; DIN = 16'd0;
    endtask

    initial begin
        int last_exp;
        int n_exp;
        repeat (3) @(negedge CK);
        RST = 0;
        check("rst_count", COUNT, 32'h0);
        check("rst_reload", RELOAD, 32'h0);
        check("rst_irq", IRQ, 0);
        check("rst_expired", EXPIRED, 0);
        check("rst_running", RUNNING, 0);

        // RELOAD=0 expires on every tick
        step(0, 0, 1, 2'd2, 16'h00B0);
        check("r0_running", RUNNING, 1);
        step(0, 0, 1, 2'd1, 16'h0000);
        check("r0_load", COUNT, 32'hFFFF_FFFF);
        step(1, 0, 0, 2'd0, 16'h0);
        check("r0_exp1", EXPIRED, 1);
        check("r0_count1", COUNT, 32'hFFFF_FFFF);
        step(1, 0, 0, 2'd0, 16'h0);
        check("r0_exp2", EXPIRED, 1);
        step(0, 0, 1, 2'd2, 16'h0000);
        check("r0_idle", RUNNING, 0);
        step(0, 0, 1, 2'd3, 16'h0002);
        check("r0_ack", IRQ, 0);

        // load while idle does not start counting
        step(0, 0, 1, 2'd2, 16'h0020);
        step(0, 0, 1, 2'd1, 16'h0010);
        check("idle_load", COUNT, 32'hFFFF_FFEF);
        step(1, 0, 0, 2'd0, 16'h0);
        check("idle_hold", COUNT, 32'hFFFF_FFEF);
        check("idle_running", RUNNING, 0);

        // reset then basic reload, halt on expiry
        step(0, 0, 1, 2'd2, 16'h0030);
        step(0, 0, 1, 2'd0, 16'h0000);
        step(0, 0, 1, 2'd1, 16'h0003);
        check("basic_load", COUNT, 32'hFFFF_FFFC);
        check("basic_reload", RELOAD, 32'h0000_0003);
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0, 2'd0, 16'h0);
            check("basic_count", COUNT, 32'hFFFF_FFFC + k);
            check("basic_noexp", EXPIRED, 0);
        end
        step(1, 0, 0, 2'd0, 16'h0);
        check("basic_exp", EXPIRED, 1);
        check("basic_irq", IRQ, 1);
        check("basic_wrap", COUNT, 32'h0);
        check("basic_halt", RUNNING, 0);
        step(1, 0, 0, 2'd0, 16'h0);
        check("halt_hold", COUNT, 32'h0);
        check("halt_single_pulse", EXPIRED, 0);

        // auto-reload, TICK every third cycle
        step(0, 0, 1, 2'd2, 16'h00B0);
        check("halt_en_rewrite", RUNNING, 0);
        step(0, 0, 1, 2'd1, 16'h0001);
        check("auto_load", COUNT, 32'hFFFF_FFFE);
        check("auto_restart", RUNNING, 1);
        last_exp = -1;
        n_exp = 0;
        for (int i = 0; i < 24; i++) begin
            step((i % 3) == 0, 0, 0, 2'd0, 16'h0);
            if ((i % 3) == 0)
                check("auto_seq", COUNT, ((i / 3) % 2 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
            if (EXPIRED) begin
                if (last_exp >= 0) check("auto_interval", i - last_exp, 6);
                last_exp = i;
                n_exp++;
            end
        end
        check("auto_nexp", n_exp, 4);

        // ack on the expiry cycle loses; a later ack wins
        step(0, 0, 1, 2'd3, 16'h0002);
        check("race_pre_ack", IRQ, 0);
        step(1, 0, 0, 2'd0, 16'h0);
        step(1, 0, 1, 2'd3, 16'h0002);
        check("race_irq_set", IRQ, 1);
        check("race_exp", EXPIRED, 1);
        step(0, 0, 1, 2'd3, 16'h0002);
        check("race_ack_later", IRQ, 0);

        // write load coincides with expiry reload
        step(1, 0, 0, 2'd0, 16'h0);
        step(1, 0, 1, 2'd1, 16'h0005);
        check("wrexp_count", COUNT, 32'hFFFF_FFFA);
        check("wrexp_exp", EXPIRED, 1);

        // VBL reload
        step(0, 0, 1, 2'd2, 16'h0050);
        step(0, 0, 1, 2'd1, 16'h0100);
        check("vbl_no_wrload", COUNT, 32'hFFFF_FFFA);
        step(1, 0, 0, 2'd0, 16'h0);
        step(1, 0, 0, 2'd0, 16'h0);
        check("vbl_pre", COUNT, 32'hFFFF_FFFC);
        step(1, 1, 0, 2'd0, 16'h0);
        check("vbl_load", COUNT, 32'hFFFF_FEFF);
        step(1, 0, 0, 2'd0, 16'h0);
        check("vbl_count", COUNT, 32'hFFFF_FF00);
        step(0, 0, 1, 2'd2, 16'h0010);
        step(1, 1, 0, 2'd0, 16'h0);
        check("vbl_disabled", COUNT, 32'hFFFF_FF01);

        // synchronous reset on the would-be expiry tick
        step(0, 0, 1, 2'd2, 16'h0030);
        step(0, 0, 1, 2'd0, 16'h0000);
        step(0, 0, 1, 2'd1, 16'h0000);
        check("rstrun_pre", COUNT, 32'hFFFF_FFFF);
        check("rstrun_irq_pre", IRQ, 1);
        RST = 1;
        step(1, 0, 0, 2'd0, 16'h0);
        RST = 0;
        check("rstrun_count", COUNT, 32'h0);
        check("rstrun_irq", IRQ, 0);
        check("rstrun_exp", EXPIRED, 0);
        check("rstrun_running", RUNNING, 0);
        step(1, 0, 0, 2'd0, 16'h0);
        check("rstrun_exp_after", EXPIRED, 0);
        check("rstrun_hold", COUNT, 32'h0);

        repeat (2) @(negedge CK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
